fp_mul_seq: RTL and testbench

//  Sequential IEEE-754 single-precision multiplier (A*B); inverse-operation companion to the fpdiv divider.

---
 rtl/fp_mul_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq -- sequential IEEE-754 single-precision multiplier (AxB = InputA * InputB).
//
// The mantissa product is built by a radix-2^BITS_PER_CYCLE shift-add loop,
// taking N = 24/BITS_PER_CYCLE cycles. One further cycle normalises, rounds and
// packs the result. Special operands (NaN, Inf, zero) are resolved on the edge
// that accepts START. The exception encoding matches the fpdiv divider.
//
// Optional feature macro: FPMUL_ROUND_NEAREST_EN
//   defined   : round-to-nearest-even using guard/round/sticky bits
//   undefined : truncation (round toward zero)
//
// Ports
//   CLOCK      in   1   clock, all state on posedge
//   RESET      in   1   asynchronous active-low reset
//   START      in   1   request; accepted only in IDLE or FIN
//   InputA     in   32  operand A, captured on accepted START
//   InputB     in   32  operand B, captured on accepted START
//   AxB        out  32  result, valid while DONE=1
//   DONE       out  1   result/exception valid
//   BUSY       out  1   multiply or normalise in progress
//   EXCEPTION  out  2   00 none, 01 underflow, 10 overflow, 11 invalid/special
module fp_mul_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] InputA,
    input  logic [31:0] InputB,
    output logic [31:0] AxB,
    output logic        DONE,
    output logic        BUSY,
    output logic [1:0]  EXCEPTION
);

    localparam int BPC = BITS_PER_CYCLE;
    localparam int N   = 24 / BITS_PER_CYCLE;

    typedef enum logic [1:0] {IDLE, MUL, NORM, FIN} state_t;

    state_t       state, state_next;
    logic         armed;
    logic         accept;
    logic [47:0]  accum;
    logic [47:0]  mcand;
    logic [23:0]  mplier;
    logic [4:0]   count;
    logic         sign;
    logic [7:0]   eff_a, eff_b;

    // Operand decode for the special-case check done on the accepting edge.
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        sign_in, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic        is_special;
    logic [31:0] spec_res;
    logic [1:0]  spec_exc;

    assign exp_a   = InputA[30:23];
    assign exp_b   = InputB[30:23];
    assign frac_a  = InputA[22:0];
    assign frac_b  = InputB[22:0];
    assign sign_in = InputA[31] ^ InputB[31];
    assign nan_a   = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b   = (exp_b == 8'hFF) && (frac_b != 23'd0);
    assign inf_a   = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b   = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign zero_a  = (exp_a == 8'h00) && (frac_a == 23'd0);
    assign zero_b  = (exp_b == 8'h00) && (frac_b == 23'd0);

    always_comb begin
        is_special = 1'b1;
        spec_res   = 32'd0;
        spec_exc   = 2'b00;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            spec_res = {sign_in, 31'h7FFFFFFF};
            spec_exc = 2'b11;
        end else if (inf_a || inf_b) begin
            spec_res = {sign_in, 8'hFF, 23'd0};
            spec_exc = 2'b11;
        end else if (zero_a || zero_b) begin
            spec_res = {sign_in, 31'd0};
            spec_exc = 2'b00;
        end else begin
            is_special = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    // Next state. "armed" blocks a START that coincides with reset release.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE, FIN: begin
                if (START && armed) begin
                    accept     = 1'b1;
                    state_next = is_special ? FIN : MUL;
                end
            end
            MUL:     if (count == 5'(N - 1)) state_next = NORM;
            NORM:    state_next = FIN;
            default: state_next = IDLE;
        endcase
    end

    // Normalise, round and pack the accumulated 48-bit product.
    logic [47:0]       p;
    logic signed [9:0] e, lim, sh, amt;
    logic [5:0]        lz;
    logic [7:0]        exp_field;
    logic [30:0]       mag, mag_r;
    logic              ovf;
    logic [31:0]       norm_res;
    logic [1:0]        norm_exc;
`ifdef FPMUL_ROUND_NEAREST_EN
    logic              sticky, guard_bit, round_bit, round_up;
`endif

    always_comb begin
        p         = accum;
        e         = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - 10'sd127;
        lz        = 6'd47;
        lim       = 10'sd0;
        sh        = 10'sd0;
        amt       = 10'sd0;
        exp_field = 8'd0;
        norm_res  = 32'd0;
        norm_exc  = 2'b00;
`ifdef FPMUL_ROUND_NEAREST_EN
        sticky    = 1'b0;
        guard_bit = 1'b0;
        round_bit = 1'b0;
        round_up  = 1'b0;
`endif
        if (p[47]) begin
`ifdef FPMUL_ROUND_NEAREST_EN
            sticky = p[0];
`endif
            p = p >> 1;
            e = e + 10'sd1;
        end else if (e > 10'sd1) begin
            // Subnormal operands: shift up to the hidden-bit position, but
            // never let the exponent drop below 1.
            for (int i = 0; i <= 46; i++) begin
                if (p[i]) lz = 6'(46 - i);
            end
            lim = e - 10'sd1;
            sh  = ($signed({4'b0000, lz}) < lim) ? $signed({4'b0000, lz}) : lim;
            p   = p << sh[5:0];
            e   = e - sh;
        end

        ovf = (e >= 10'sd255);

        // Results below the normal range are denormalised by (1-e).
        if (e <= 10'sd0) begin
            amt = 10'sd1 - e;
            if (amt >= 10'sd48) begin
`ifdef FPMUL_ROUND_NEAREST_EN
                sticky = sticky | (|p);
`endif
                p = 48'd0;
            end else begin
`ifdef FPMUL_ROUND_NEAREST_EN
                sticky = sticky | (|(p & ~({48{1'b1}} << amt[5:0])));
`endif
                p = p >> amt[5:0];
            end
        end

        // A clear hidden bit means the result is subnormal: exponent field 0.
        exp_field = p[46] ? e[7:0] : 8'd0;
        mag       = {exp_field, p[45:23]};
`ifdef FPMUL_ROUND_NEAREST_EN
        guard_bit = p[22];
        round_bit = p[21];
        sticky    = sticky | (|p[20:0]);
        round_up  = guard_bit & (round_bit | sticky | p[23]);
        mag_r     = mag + {30'd0, round_up};
`else
        mag_r     = mag;
`endif
        // Rounding carry can push the exponent field to all-ones.
        if (ovf || (mag_r[30:23] == 8'hFF)) begin
            norm_res = {sign, 8'hFF, 23'd0};
            norm_exc = 2'b10;
        end else if (mag_r == 31'd0) begin
            norm_res = {sign, 31'd0};
            norm_exc = 2'b01;
        end else begin
            norm_res = {sign, mag_r};
            norm_exc = 2'b00;
        end
    end

    // Datapath and registered outputs.
    logic [47:0] digit;
    assign digit = {{(48 - BPC){1'b0}}, mplier[BPC-1:0]};

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            armed     <= 1'b0;
            accum     <= 48'd0;
            mcand     <= 48'd0;
            mplier    <= 24'd0;
            count     <= 5'd0;
            sign      <= 1'b0;
            eff_a     <= 8'd0;
            eff_b     <= 8'd0;
            AxB       <= 32'd0;
            DONE      <= 1'b0;
            BUSY      <= 1'b0;
            EXCEPTION <= 2'b00;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                sign   <= sign_in;
                eff_a  <= (exp_a == 8'd0) ? 8'd1 : exp_a;
                eff_b  <= (exp_b == 8'd0) ? 8'd1 : exp_b;
                mcand  <= {24'd0, (exp_a != 8'd0), frac_a};
                mplier <= {(exp_b != 8'd0), frac_b};
                accum  <= 48'd0;
                count  <= 5'd0;
                if (is_special) begin
                    AxB       <= spec_res;
                    EXCEPTION <= spec_exc;
                    DONE      <= 1'b1;
                    BUSY      <= 1'b0;
                end else begin
                    DONE <= 1'b0;
                    BUSY <= 1'b1;
                end
            end else if (state == MUL) begin
                // Multiplier consumed LSB first; multiplicand tracks its weight.
                accum  <= accum + mcand * digit;
                mcand  <= mcand << BPC;
                mplier <= mplier >> BPC;
                count  <= count + 5'd1;
            end else if (state == NORM) begin
                AxB       <= norm_res;
                EXCEPTION <= norm_exc;
                DONE      <= 1'b1;
                BUSY      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq -- directed self-checking bench for fp_mul_seq.
// Expected results are hand-computed IEEE-754 values; the rounding macro
// FPMUL_ROUND_NEAREST_EN selects the expected value where the two builds differ.
module tb_fp_mul_seq;

    localparam int BPC = 1;
    localparam int N   = 24 / BPC;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [31:0] InputA = 32'd0;
    logic [31:0] InputB = 32'd0;
    logic [31:0] AxB;
    logic        DONE;
    logic        BUSY;
    logic [1:0]  EXCEPTION;

    int vectorCount = 0;
    int missCount   = 0;

    fp_mul_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START),
        .InputA(InputA), .InputB(InputB),
        .AxB(AxB), .DONE(DONE), .BUSY(BUSY), .EXCEPTION(EXCEPTION)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One operation: START for one edge, count edges (accepting edge = 1)
    // until DONE, and count edges after which BUSY was high. With poke set,
    // START is re-asserted with special operands mid-operation and must be ignored.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input logic [1:0] expExc,
                                 input int expLat, input int expBusy, input bit poke);
        int lat;
        int busyCnt;
        @(negedge CLOCK);
        InputA = a;
        InputB = b;
        START  = 1'b1;
        lat     = 0;
        busyCnt = 0;
        do begin
            @(posedge CLOCK);
            #1;
            lat++;
            if (lat == 1) START = 1'b0;
            if (poke && lat == 3) begin
                START  = 1'b1;
                InputA = 32'h7F800000;
                InputB = 32'h00000000;
            end
            if (poke && lat == 5) START = 1'b0;
            if (BUSY) busyCnt++;
        end while (!DONE && lat < 200);
        checkOutput({tag, "/done"}, {31'd0, DONE}, 32'd1);
        checkOutput({tag, "/res"}, AxB, expRes);
        checkOutput({tag, "/exc"}, {30'd0, EXCEPTION}, {30'd0, expExc});
        checkOutput({tag, "/lat"}, lat, expLat);
        checkOutput({tag, "/busy"}, busyCnt, expBusy);
    endtask

    initial begin
        logic [31:0] expT2;
`ifdef FPMUL_ROUND_NEAREST_EN
        expT2 = 32'h40100002;
`else
        expT2 = 32'h40100001;
`endif
        $display("[TB] start, N=%0d", N);

        // Reset state.
        #12;
        checkOutput("rst/res",  AxB, 32'd0);
        checkOutput("rst/done", {31'd0, DONE}, 32'd0);
        checkOutput("rst/busy", {31'd0, BUSY}, 32'd0);
        checkOutput("rst/exc",  {30'd0, EXCEPTION}, 32'd0);

        // START coincident with reset release must be ignored.
        @(negedge CLOCK);
        RESET  = 1'b1;
        START  = 1'b1;
        InputA = 32'h3FC00000;
        InputB = 32'h40000000;
        @(posedge CLOCK);
        #1;
        START = 1'b0;
        checkOutput("relStart/busy", {31'd0, BUSY}, 32'd0);
        checkOutput("relStart/done", {31'd0, DONE}, 32'd0);

        applyStimulus("t1",      32'h3FC00000, 32'h40000000, 32'h40400000, 2'b00, N + 2, N + 1, 1'b0);
        applyStimulus("t2",      32'h3FC00001, 32'h3FC00001, expT2,        2'b00, N + 2, N + 1, 1'b0);
        applyStimulus("ovf",     32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 2'b10, N + 2, N + 1, 1'b0);
        applyStimulus("unf",     32'h00800000, 32'h00800000, 32'h00000000, 2'b01, N + 2, N + 1, 1'b0);
        applyStimulus("infx0",   32'h7F800000, 32'h00000000, 32'h7FFFFFFF, 2'b11, 1, 0, 1'b0);
        applyStimulus("ninfxinf",32'hBF800000, 32'h7F800000, 32'hFF800000, 2'b11, 1, 0, 1'b0);
        applyStimulus("subIn",   32'h00400000, 32'h40000000, 32'h00800000, 2'b00, N + 2, N + 1, 1'b0);
        applyStimulus("neg",     32'h3FC00000, 32'hC0000000, 32'hC0400000, 2'b00, N + 2, N + 1, 1'b0);
        applyStimulus("negZero", 32'h80000000, 32'h3F800000, 32'h80000000, 2'b00, 1, 0, 1'b0);
        applyStimulus("nan",     32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 2'b11, 1, 0, 1'b0);
        applyStimulus("subOut",  32'h00800000, 32'h3F000000, 32'h00400000, 2'b00, N + 2, N + 1, 1'b0);
        applyStimulus("busyIgn", 32'h3FC00000, 32'h40000000, 32'h40400000, 2'b00, N + 2, N + 1, 1'b1);

        // Reset in the middle of MUL clears every output at once.
        @(negedge CLOCK);
        InputA = 32'h3FC00001;
        InputB = 32'h3FC00001;
        START  = 1'b1;
        @(posedge CLOCK);
        #1;
        START = 1'b0;
        repeat (10) @(posedge CLOCK);
        #3;
        RESET = 1'b0;
        #1;
        checkOutput("midRst/res",  AxB, 32'd0);
        checkOutput("midRst/done", {31'd0, DONE}, 32'd0);
        checkOutput("midRst/busy", {31'd0, BUSY}, 32'd0);
        checkOutput("midRst/exc",  {30'd0, EXCEPTION}, 32'd0);
        @(negedge CLOCK);
        RESET = 1'b1;
        applyStimulus("t6", 32'h3FC00000, 32'h40000000, 32'h40400000, 2'b00, N + 2, N + 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
